// File: rtl/alarm_time_ctrl_if.sv
// Button, IRQ and display bundle between the alarm clock controller and its surroundings.
interface alarm_time_ctrl_if;
    logic       timer_irq_irq;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_snooze;
    logic       alarm_en;
    logic [7:0] digit_h1;
    logic [7:0] digit_h2;
    logic [7:0] digit_m1;
    logic [7:0] digit_m2;
    logic [7:0] digit_s1;
    logic [7:0] digit_s2;
    logic       alarm_ring;
    logic [2:0] mode;

    // Driver of buttons and IRQ
    modport master (
        output timer_irq_irq, btn_mode, btn_inc, btn_snooze, alarm_en,
        input  digit_h1, digit_h2, digit_m1, digit_m2, digit_s1, digit_s2, alarm_ring, mode
    );

    // The controller itself
    modport slave (
        input  timer_irq_irq, btn_mode, btn_inc, btn_snooze, alarm_en,
        output digit_h1, digit_h2, digit_m1, digit_m2, digit_s1, digit_s2, alarm_ring, mode
    );
endinterface

// File: rtl/alarm_time_ctrl.sv
// HH:MM:SS BCD clock with set modes, one alarm, snooze and ring timeout.
module alarm_time_ctrl #(
    parameter int unsigned SNOOZE_MIN     = 5,
    parameter int unsigned RING_TIMEOUT_S = 60
) (
    input logic              clk_clk,
    input logic              reset_reset,
    alarm_time_ctrl_if.slave bus_io
);

    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StSetHr  = 3'd1,
        StSetMin = 3'd2,
        StAlmHr  = 3'd3,
        StAlmMin = 3'd4
    } mode_e;

    // Next packed-BCD value, wrapping to 00 after 'last'.
    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] last);
        if (v == last) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    mode_e      mode_q, mode_d;
    logic       irq_q;
    logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [7:0] alm_hh_q, alm_hh_d, alm_mm_q, alm_mm_d;
    logic [7:0] snz_hh_q, snz_hh_d, snz_mm_q, snz_mm_d;
    logic       snz_pend_q, snz_pend_d;
    logic       ring_q, ring_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic [7:0] disp_h_q, disp_h_d, disp_m_q, disp_m_d, disp_s_q, disp_s_d;

    logic       tick, time_run, inc_ok, trig;
    logic [7:0] ss_inc, mm_inc, hh_inc, alm_hh_inc, alm_mm_inc;
    logic [7:0] snz_hh_new, snz_mm_new;
    logic [6:0] min_bin, min_sum, min_wrap;
    logic [4:0] hr_bin, hr_adj, hr_wrap;

    assign tick     = bus_io.timer_irq_irq & ~irq_q;
    assign time_run = tick & (mode_q inside {StRun, StAlmHr, StAlmMin});
    // A simultaneous mode press swallows the increment.
    assign inc_ok   = bus_io.btn_inc & ~bus_io.btn_mode;

    assign ss_inc     = bcd_next(ss_q, 8'h59);
    assign mm_inc     = bcd_next(mm_q, 8'h59);
    assign hh_inc     = bcd_next(hh_q, 8'h23);
    assign alm_hh_inc = bcd_next(alm_hh_q, 8'h23);
    assign alm_mm_inc = bcd_next(alm_mm_q, 8'h59);

    // Mode FSM: btn_mode steps through the five modes; stray codes fall back to RUN.
    always_comb begin
        mode_d = mode_q;
        if (bus_io.btn_mode) begin
            case (mode_q)
                StRun:    mode_d = StSetHr;
                StSetHr:  mode_d = StSetMin;
                StSetMin: mode_d = StAlmHr;
                StAlmHr:  mode_d = StAlmMin;
                default:  mode_d = StRun;
            endcase
        end else if (!(mode_q inside {StRun, StSetHr, StSetMin, StAlmHr, StAlmMin})) begin
            mode_d = StRun;
        end
    end

    // Time and alarm registers: seconds tick with carry, button increments without carry.
    always_comb begin
        hh_d     = hh_q;
        mm_d     = mm_q;
        ss_d     = ss_q;
        alm_hh_d = alm_hh_q;
        alm_mm_d = alm_mm_q;
        if (time_run) begin
            ss_d = ss_inc;
            if (ss_q == 8'h59) begin
                mm_d = mm_inc;
                if (mm_q == 8'h59) begin
                    hh_d = hh_inc;
                end
            end
        end
        if (inc_ok) begin
            case (mode_q)
                StSetHr:  hh_d = hh_inc;
                StSetMin: begin
                    mm_d = mm_inc;
                    ss_d = 8'h00;
                end
                StAlmHr:  alm_hh_d = alm_hh_inc;
                StAlmMin: alm_mm_d = alm_mm_inc;
                default:  ;
            endcase
        end
    end

    // Snooze target: current hh:mm plus SNOOZE_MIN, done in binary then back to BCD.
    always_comb begin
        min_bin  = 7'(mm_q[7:4]) * 7'd10 + 7'(mm_q[3:0]);
        min_sum  = min_bin + 7'(SNOOZE_MIN);
        hr_bin   = 5'(hh_q[7:4]) * 5'd10 + 5'(hh_q[3:0]);
        hr_adj   = hr_bin;
        min_wrap = min_sum;
        if (min_sum >= 7'd60) begin
            min_wrap = min_sum - 7'd60;
            hr_adj   = hr_bin + 5'd1;
        end
        hr_wrap    = (hr_adj >= 5'd24) ? 5'd0 : hr_adj;
        snz_mm_new = {4'(min_wrap / 7'd10), 4'(min_wrap % 7'd10)};
        snz_hh_new = {4'(hr_wrap / 5'd10), 4'(hr_wrap % 5'd10)};
    end

    // Trigger on the tick that lands exactly on the alarm or a pending snooze target.
    assign trig = (mode_q == StRun) & bus_io.alarm_en & tick & (ss_d == 8'h00) &
                  (((hh_d == alm_hh_q) & (mm_d == alm_mm_q)) |
                   (snz_pend_q & (hh_d == snz_hh_q) & (mm_d == snz_mm_q)));

    // Ring/snooze control; disable beats mode press beats snooze beats trigger beats timeout.
    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        snz_pend_d = snz_pend_q;
        snz_hh_d   = snz_hh_q;
        snz_mm_d   = snz_mm_q;
        if (!bus_io.alarm_en || bus_io.btn_mode) begin
            ring_d     = 1'b0;
            snz_pend_d = 1'b0;
        end else if (bus_io.btn_snooze && ring_q) begin
            ring_d     = 1'b0;
            snz_pend_d = 1'b1;
            snz_hh_d   = snz_hh_new;
            snz_mm_d   = snz_mm_new;
        end else if (trig) begin
            ring_d     = 1'b1;
            ring_cnt_d = 8'd0;
        end else if (ring_q && tick) begin
            ring_cnt_d = ring_cnt_q + 8'd1;
            if (ring_cnt_d == 8'(RING_TIMEOUT_S)) begin
                ring_d = 1'b0;
            end
        end
    end

    // Display source: alarm HH:MM in the alarm-set modes, live time otherwise.
    always_comb begin
        disp_h_d = hh_q;
        disp_m_d = mm_q;
        disp_s_d = ss_q;
        if (mode_q == StAlmHr || mode_q == StAlmMin) begin
            disp_h_d = alm_hh_q;
            disp_m_d = alm_mm_q;
            disp_s_d = 8'h00;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            mode_q     <= StRun;
            irq_q      <= 1'b0;
            hh_q       <= 8'h00;
            mm_q       <= 8'h00;
            ss_q       <= 8'h00;
            alm_hh_q   <= 8'h00;
            alm_mm_q   <= 8'h00;
            snz_hh_q   <= 8'h00;
            snz_mm_q   <= 8'h00;
            snz_pend_q <= 1'b0;
            ring_q     <= 1'b0;
            ring_cnt_q <= 8'd0;
            disp_h_q   <= 8'h00;
            disp_m_q   <= 8'h00;
            disp_s_q   <= 8'h00;
        end else begin
            mode_q     <= mode_d;
            irq_q      <= bus_io.timer_irq_irq;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            alm_hh_q   <= alm_hh_d;
            alm_mm_q   <= alm_mm_d;
            snz_hh_q   <= snz_hh_d;
            snz_mm_q   <= snz_mm_d;
            snz_pend_q <= snz_pend_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
            disp_h_q   <= disp_h_d;
            disp_m_q   <= disp_m_d;
            disp_s_q   <= disp_s_d;
        end
    end

    assign bus_io.digit_h1   = {4'h0, disp_h_q[7:4]};
    assign bus_io.digit_h2   = {4'h0, disp_h_q[3:0]};
    assign bus_io.digit_m1   = {4'h0, disp_m_q[7:4]};
    assign bus_io.digit_m2   = {4'h0, disp_m_q[3:0]};
    assign bus_io.digit_s1   = {4'h0, disp_s_q[7:4]};
    assign bus_io.digit_s2   = {4'h0, disp_s_q[3:0]};
    assign bus_io.alarm_ring = ring_q;
    assign bus_io.mode       = mode_q;

endmodule

// File: tb/tb_alarm_time_ctrl.sv
// Bench for alarm_time_ctrl: vector table, directed corner sequences, random run vs model.
module tb_alarm_time_ctrl;
    localparam int SNZ = 5;
    localparam int RTO = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alarm_time_ctrl_if bus ();

    alarm_time_ctrl #(
        .SNOOZE_MIN    (SNZ),
        .RING_TIMEOUT_S(RTO)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .bus_io     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic cur_en = 1'b0;

    // Reference model: time as seconds of day, alarm/snooze as minutes of day.
    int m_t, m_alm, m_snz, m_pend, m_ring, m_cnt, m_mode, m_irq;
    int m_dh, m_dm, m_ds;

    logic [47:0] dut_digits;
    assign dut_digits = {bus.digit_h1, bus.digit_h2, bus.digit_m1,
                         bus.digit_m2, bus.digit_s1, bus.digit_s2};

    typedef struct {
        logic        irq;
        logic        bm;
        logic        bi;
        logic [2:0]  mode;
        logic        ring;
        logic [23:0] disp;
    } vec_t;
    vec_t tbl [14];

    function automatic logic [47:0] digits_of(input int h, input int m, input int s);
        return {4'h0, 4'(h / 10), 4'h0, 4'(h % 10), 4'h0, 4'(m / 10),
                4'h0, 4'(m % 10), 4'h0, 4'(s / 10), 4'h0, 4'(s % 10)};
    endfunction

    function automatic logic [47:0] expand(input logic [23:0] b);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[i*8 +: 8] = {4'h0, b[i*4 +: 4]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic irq, bm, bi, bs, en, r);
        int nt, nalm, h, m, s;
        bit tick, trig;
        if (r) begin
            m_t = 0; m_alm = 0; m_snz = 0; m_pend = 0; m_ring = 0; m_cnt = 0;
            m_mode = 0; m_irq = 0; m_dh = 0; m_dm = 0; m_ds = 0;
        end else begin
            tick  = irq && (m_irq == 0);
            m_irq = int'(irq);
            if (m_mode == 3 || m_mode == 4) begin
                m_dh = m_alm / 60; m_dm = m_alm % 60; m_ds = 0;
            end else begin
                m_dh = m_t / 3600; m_dm = (m_t / 60) % 60; m_ds = m_t % 60;
            end
            nt = m_t;
            nalm = m_alm;
            if (tick && m_mode != 1 && m_mode != 2) nt = (nt + 1) % 86400;
            h = nt / 3600; m = (nt / 60) % 60; s = nt % 60;
            if (bi && !bm) begin
                case (m_mode)
                    1: nt = ((h + 1) % 24) * 3600 + m * 60 + s;
                    2: nt = h * 3600 + ((m + 1) % 60) * 60;
                    3: nalm = ((m_alm / 60 + 1) % 24) * 60 + m_alm % 60;
                    4: nalm = (m_alm / 60) * 60 + (m_alm % 60 + 1) % 60;
                    default: ;
                endcase
            end
            trig = (m_mode == 0) && en && tick && (nt % 60 == 0) &&
                   ((nt / 60 == m_alm) || (m_pend != 0 && nt / 60 == m_snz));
            if (!en || bm) begin
                m_ring = 0; m_pend = 0;
            end else if (bs && m_ring != 0) begin
                m_ring = 0; m_pend = 1; m_snz = (m_t / 60 + SNZ) % 1440;
            end else if (trig) begin
                m_ring = 1; m_cnt = 0;
            end else if (m_ring != 0 && tick) begin
                m_cnt++;
                if (m_cnt == RTO) m_ring = 0;
            end
            if (bm) m_mode = (m_mode + 1) % 5;
            m_t = nt;
            m_alm = nalm;
        end
    endtask

    // One clock: drive at negedge, step model at posedge, compare just after.
    task automatic cyc(input logic irq, bm, bi, bs, en, r);
        @(negedge clk);
        bus.timer_irq_irq = irq;
        bus.btn_mode      = bm;
        bus.btn_inc       = bi;
        bus.btn_snooze    = bs;
        bus.alarm_en      = en;
        rst               = r;
        @(posedge clk);
        model_step(irq, bm, bi, bs, en, r);
        #1;
        chk("model_digits", dut_digits, digits_of(m_dh, m_dm, m_ds));
        chk("model_ring", 48'(bus.alarm_ring), 48'(m_ring));
        chk("model_mode", 48'(bus.mode), 48'(m_mode));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, cur_en, 1'b0);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, cur_en, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, cur_en, 1'b0);
        end
    endtask

    task automatic press_mode();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, cur_en, 1'b0);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, cur_en, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, cur_en, 1'b1);
    endtask

    // Time 07:29:00, alarm 07:30, back in RUN.
    task automatic setup_0729();
        do_reset();
        press_mode(); press_inc(7);
        press_mode(); press_inc(29);
        press_mode(); press_inc(7);
        press_mode(); press_inc(30);
        press_mode();
    endtask

    // Ring at 07:30:00.
    task automatic ring_at_0730();
        cur_en = 1'b0;
        setup_0729();
        cur_en = 1'b1;
        tick_n(59);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, cur_en, 1'b0);
        chk("ring_on_match", 48'(bus.alarm_ring), 48'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, cur_en, 1'b0);
    endtask

    initial begin
        logic ri, rbm, rbi, rbs, ren, rr;
        bus.timer_irq_irq = 1'b0;
        bus.btn_mode      = 1'b0;
        bus.btn_inc       = 1'b0;
        bus.btn_snooze    = 1'b0;
        bus.alarm_en      = 1'b0;

        // irq, bm, bi, expected mode, ring, displayed HHMMSS (state before the edge)
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 24'h000000};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 24'h000000};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 24'h010000};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 24'h020000};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 24'h020000};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 24'h020100};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 24'h020100};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 24'h020100};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 24'h000000};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 24'h010000};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 24'h010000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 24'h010100};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'h010100};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 24'h020101};

        // Reset state
        do_reset();
        chk("reset_digits", dut_digits, 48'h0);
        chk("reset_ring", 48'(bus.alarm_ring), 48'd0);
        chk("reset_mode", 48'(bus.mode), 48'd0);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].irq, tbl[i].bm, tbl[i].bi, 1'b0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_mode", i), 48'(bus.mode), 48'(tbl[i].mode));
            chk($sformatf("tbl%0d_ring", i), 48'(bus.alarm_ring), 48'(tbl[i].ring));
            chk($sformatf("tbl%0d_digits", i), dut_digits, expand(tbl[i].disp));
        end

        // 3661 ticks from reset
        do_reset();
        tick_n(3661);
        chk("t3661_digits", dut_digits, 48'h00_01_00_01_00_01);
        chk("t3661_mode", 48'(bus.mode), 48'd0);

        // 23:59:50 then ten ticks to midnight
        do_reset();
        press_mode(); press_inc(23);
        press_mode(); press_inc(59);
        press_mode(); press_mode(); press_mode();
        tick_n(50);
        chk("pre_wrap", dut_digits, digits_of(23, 59, 50));
        tick_n(10);
        chk("midnight_wrap", dut_digits, 48'h0);

        // Set-mode wraps and frozen clock
        tick_n(5);
        press_mode(); press_inc(24); idle(1);
        chk("hr_24_inc", dut_digits, digits_of(0, 0, 5));
        tick_n(3);
        chk("set_hr_frozen", dut_digits, digits_of(0, 0, 5));
        press_mode(); press_inc(61); idle(1);
        chk("min_61_inc", dut_digits, digits_of(0, 1, 0));
        tick_n(3);
        chk("set_min_frozen", dut_digits, digits_of(0, 1, 0));
        press_mode(); press_mode(); press_mode();

        // Alarm match and timeout
        ring_at_0730();
        tick_n(59);
        chk("ring_before_timeout", 48'(bus.alarm_ring), 48'd1);
        tick_n(1);
        chk("ring_timeout", 48'(bus.alarm_ring), 48'd0);

        // Snooze
        ring_at_0730();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, cur_en, 1'b0);
        chk("snooze_stops", 48'(bus.alarm_ring), 48'd0);
        tick_n(299);
        chk("snooze_early", 48'(bus.alarm_ring), 48'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, cur_en, 1'b0);
        chk("snooze_fires", 48'(bus.alarm_ring), 48'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, cur_en, 1'b0);

        // Snooze then disable: no ring
        ring_at_0730();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, cur_en, 1'b0);
        cur_en = 1'b0;
        tick_n(300);
        chk("snooze_disabled", 48'(bus.alarm_ring), 48'd0);

        // Mode and inc together, then reset mid-ring
        do_reset();
        press_mode();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, cur_en, 1'b0);
        chk("mode_beats_inc", 48'(bus.mode), 48'd2);
        idle(1);
        chk("mode_inc_hour", dut_digits, 48'h0);
        ring_at_0730();
        do_reset();
        chk("midring_reset_digits", dut_digits, 48'h0);
        chk("midring_reset_ring", 48'(bus.alarm_ring), 48'd0);
        chk("midring_reset_mode", 48'(bus.mode), 48'd0);

        // Random run near the alarm against the model
        cur_en = 1'b0;
        setup_0729();
        cur_en = 1'b1;
        tick_n(55);
        for (int i = 0; i < 4000; i++) begin
            ri  = 1'($urandom_range(0, 1));
            rbm = ($urandom_range(0, 63) == 0);
            rbi = ($urandom_range(0, 3) == 0);
            rbs = ($urandom_range(0, 7) == 0);
            ren = ($urandom_range(0, 15) != 0);
            rr  = ($urandom_range(0, 1999) == 0);
            cyc(ri, rbm, rbi, rbs, ren, rr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
